// File: rtl/baud_tick_gen_if.sv
// Bus bundle for baud_tick_gen: enable/restart control, runtime divisor and
// oversample configuration going in, and the three tick strobes coming out.
// The master side drives configuration; the slave side (the generator) drives ticks.
interface baud_tick_gen_if #(
    parameter int DIV_W  = 16,
    parameter int FRAC_W = 4,
    parameter int OSR_W  = 5
);
    logic              en;
    logic              restart;
    logic [DIV_W-1:0]  div_int;
    logic [FRAC_W-1:0] div_frac;
    logic [OSR_W-1:0]  osr;
    logic              s_tick;
    logic              mid_tick;
    logic              b_tick;

    modport master (
        output en, restart, div_int, div_frac, osr,
        input  s_tick, mid_tick, b_tick
    );

    modport slave (
        input  en, restart, div_int, div_frac, osr,
        output s_tick, mid_tick, b_tick
    );
endinterface

// File: rtl/baud_tick_gen.sv
// Baud tick generator for the UART bit engines.
// A prescaler divides clk into an oversample tick (s_tick); a sample counter
// groups s_ticks into bits and flags the mid-bit sample (mid_tick) and the last
// sample of the bit (b_tick). Divisor and oversample ratio are held in shadow
// registers that only reload at a bit boundary, on restart, or when counting
// resumes, so mid-bit input changes never stretch or shrink the current bit.
// Optional build macro BAUD_FRAC_EN adds a fractional-divisor accumulator that
// lengthens selected s_tick periods by one clock; without it the period is
// exactly div_int+1 clocks and div_frac is ignored.
module baud_tick_gen #(
    parameter int DIV_W  = 16,
    parameter int FRAC_W = 4,
    parameter int OSR_W  = 5
) (
    input  logic               clk,
    input  logic               reset_n,
    baud_tick_gen_if.slave     bus
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic              r_en_d;        // en seen on the previous clock
    logic [DIV_W-1:0]  r_div_int_q;   // shadow integer divisor
    logic [OSR_W-1:0]  r_osr_q;       // shadow oversample ratio
    logic [DIV_W:0]    r_cnt;         // prescaler, one bit wider than div_int
    logic [OSR_W-1:0]  r_scnt;        // sample index within the current bit
    logic              r_s_tick;
    logic              r_mid_tick;
    logic              r_b_tick;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic              w_first_en;    // first counting cycle after en was low
    logic [DIV_W-1:0]  w_div_eff;     // divisor in force this cycle
    logic [OSR_W-1:0]  w_osr_eff;     // oversample ratio in force this cycle
    logic              w_ext;         // one-clock period extension from the fraction
    logic [DIV_W:0]    w_limit;       // terminal prescaler count
    logic              w_wrap;        // prescaler wraps -> s_tick next cycle
    logic              w_bit_end;     // wrap on the last sample of a bit
    logic              w_mid_hit;     // wrap on the middle sample of a bit
    logic              w_capture;     // reload shadow configuration

    assign w_first_en = bus.en & ~r_en_d;

    // On the first cycle of a counting run the shadow copy is not loaded yet,
    // so the live inputs are used directly; this keeps the first period exact.
    assign w_div_eff = w_first_en ? bus.div_int : r_div_int_q;
    assign w_osr_eff = w_first_en ? bus.osr     : r_osr_q;

    // Width-extended sum cannot overflow, so div_int at its maximum plus a
    // fractional extension still compares correctly.
    assign w_limit = {1'b0, w_div_eff} + {{DIV_W{1'b0}}, w_ext};

    // Greater-or-equal rather than equality: if a resumed run loads a smaller
    // divisor than the count already reached, the period ends at once instead
    // of running the wide counter all the way round.
    assign w_wrap    = bus.en & ~bus.restart & (r_cnt >= w_limit);
    assign w_bit_end = w_wrap & (r_scnt >= w_osr_eff);
    assign w_mid_hit = w_wrap & (r_scnt == (w_osr_eff >> 1));

    assign w_capture = bus.restart | w_first_en | w_bit_end;

`ifdef BAUD_FRAC_EN
    // ------------------------------------------------------------------
    // Fractional accumulator
    // ------------------------------------------------------------------
    logic [FRAC_W-1:0] r_div_frac_q;  // shadow fractional divisor
    logic [FRAC_W-1:0] r_acc;         // fractional phase, wraps mod 2^FRAC_W
    logic              r_ext;         // carry out: next period one clock longer
    logic [FRAC_W-1:0] w_frac_eff;
    logic [FRAC_W:0]   w_acc_sum;

    assign w_frac_eff = w_first_en ? bus.div_frac : r_div_frac_q;
    assign w_acc_sum  = {1'b0, r_acc} + {1'b0, w_frac_eff};
    assign w_ext      = r_ext;

    // Accumulate the fraction once per s_tick period; carry stretches the next period.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_acc <= '0;
            r_ext <= 1'b0;
        end else if (bus.restart) begin
            r_acc <= '0;
            r_ext <= 1'b0;
        end else if (w_wrap) begin
            {r_ext, r_acc} <= w_acc_sum;
        end
    end

    // Fractional shadow reloads on the same events as the integer shadow.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_div_frac_q <= '0;
        end else if (w_capture) begin
            r_div_frac_q <= bus.div_frac;
        end
    end
`else
    // Integer-only build: no period extension, div_frac has no effect.
    logic w_unused_div_frac;

    assign w_ext             = 1'b0;
    assign w_unused_div_frac = ^bus.div_frac;
`endif

    // ------------------------------------------------------------------
    // Sequential logic
    // ------------------------------------------------------------------

    // Remember en so a rising enable can be recognised as a fresh run.
    // NOTE: every register here is a small control/state flop, so all of them
    // take the async reset; state updates use non-blocking assignments so
    // each block reads the pre-edge value of every other register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_en_d <= 1'b0;
        end else begin
            r_en_d <= bus.en;
        end
    end

    // Shadow configuration: reload only at safe points so a bit in progress
    // keeps the timing it started with.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_div_int_q <= '0;
            r_osr_q     <= '0;
        end else if (w_capture) begin
            r_div_int_q <= bus.div_int;
            r_osr_q     <= bus.osr;
        end
    end

    // Prescaler and sample counter; restart clears both regardless of en,
    // and a low en freezes them where they are.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt  <= '0;
            r_scnt <= '0;
        end else if (bus.restart) begin
            r_cnt  <= '0;
            r_scnt <= '0;
        end else if (bus.en) begin
            if (w_wrap) begin
                r_cnt  <= '0;
                r_scnt <= w_bit_end ? '0 : r_scnt + OSR_W'(1);
            end else begin
                r_cnt  <= r_cnt + (DIV_W + 1)'(1);
            end
        end
    end

    // Registered strobes, all three aligned to the same cycle; the wrap terms
    // are already gated by en and restart, so the strobes drop when either acts.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s_tick   <= 1'b0;
            r_mid_tick <= 1'b0;
            r_b_tick   <= 1'b0;
        end else begin
            r_s_tick   <= w_wrap;
            r_mid_tick <= w_mid_hit;
            r_b_tick   <= w_bit_end;
        end
    end

    assign bus.s_tick   = r_s_tick;
    assign bus.mid_tick = r_mid_tick;
    assign bus.b_tick   = r_b_tick;

endmodule

// File: tb/tb_baud_tick_gen.sv
// Self-checking bench for baud_tick_gen. A per-period reference model predicts
// every strobe cycle by cycle; directed scenarios additionally check tick
// spacing against figures worked out by hand. Honours BAUD_FRAC_EN if defined.
module tb_baud_tick_gen;

    localparam int DIV_W  = 16;
    localparam int FRAC_W = 4;
    localparam int OSR_W  = 5;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    always #5 clk = ~clk;

    baud_tick_gen_if #(.DIV_W(DIV_W), .FRAC_W(FRAC_W), .OSR_W(OSR_W)) bus ();

    baud_tick_gen #(.DIV_W(DIV_W), .FRAC_W(FRAC_W), .OSR_W(OSR_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: tracks elapsed clocks in the current s_tick period,
    // the sample number within the bit and the fractional phase.
    // ------------------------------------------------------------------
    int m_div, m_frac, m_osr, m_elapsed, m_acc, m_ext, m_k;
    bit m_en_prev;
    bit e_s, e_m, e_b;

    int step_n = 0;
    int s_q[$];
    int m_q[$];
    int b_q[$];

    task automatic model_reset();
        m_div = 0; m_frac = 0; m_osr = 0;
        m_elapsed = 0; m_acc = 0; m_ext = 0; m_k = 0;
        m_en_prev = 1'b0;
    endtask

    task automatic model_load();
        m_div  = int'(bus.div_int);
        m_frac = int'(bus.div_frac);
        m_osr  = int'(bus.osr);
    endtask

    // Predict the strobes produced by the coming clock edge from the inputs now applied.
    task automatic model_edge();
        e_s = 1'b0; e_m = 1'b0; e_b = 1'b0;
        if (bus.restart) begin
            m_elapsed = 0; m_k = 0; m_acc = 0; m_ext = 0;
            model_load();
        end else if (bus.en) begin
            if (!m_en_prev) model_load();
            if (m_elapsed >= m_div + m_ext) begin
                e_s = 1'b1;
                e_m = (m_k == m_osr / 2);
                e_b = (m_k >= m_osr);
`ifdef BAUD_FRAC_EN
                m_acc = m_acc + m_frac;
                m_ext = (m_acc >= (1 << FRAC_W)) ? 1 : 0;
                m_acc = m_acc % (1 << FRAC_W);
`endif
                m_elapsed = 0;
                if (e_b) begin
                    m_k = 0;
                    model_load();
                end else begin
                    m_k++;
                end
            end else begin
                m_elapsed++;
            end
        end
        m_en_prev = bus.en;
    endtask

    // One clock: predict, clock, then compare and log on the falling edge.
    task automatic step();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        step_n++;
        check("s_tick",   32'(bus.s_tick),   32'(e_s));
        check("mid_tick", 32'(bus.mid_tick), 32'(e_m));
        check("b_tick",   32'(bus.b_tick),   32'(e_b));
        if (bus.s_tick   === 1'b1) s_q.push_back(step_n);
        if (bus.mid_tick === 1'b1) m_q.push_back(step_n);
        if (bus.b_tick   === 1'b1) b_q.push_back(step_n);
    endtask

    task automatic clear_logs();
        s_q.delete(); m_q.delete(); b_q.delete();
    endtask

    function automatic int qat(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -100000;
    endfunction

    // Step until n s_ticks are logged, giving up after budget clocks.
    task automatic run_until_s(input int n, input int budget);
        int left = budget;
        while (s_q.size() < n && left > 0) begin
            step();
            left--;
        end
        check("wait_s_tick", s_q.size(), n);
    endtask

    // Apply a restart with the given configuration; returns the restart step.
    task automatic do_restart(input int di, input int df, input int os, output int r_step);
        bus.restart  = 1'b1;
        bus.en       = 1'b1;
        bus.div_int  = DIV_W'(di);
        bus.div_frac = FRAC_W'(df);
        bus.osr      = OSR_W'(os);
        step();
        r_step      = step_n;
        bus.restart = 1'b0;
        clear_logs();
    endtask

    int r_step;
    int st;
    int cnt_s, cnt_m, cnt_b;

    initial begin
        bus.en = 1'b0; bus.restart = 1'b0;
        bus.div_int = '0; bus.div_frac = '0; bus.osr = '0;
        model_reset();

        // Reset state.
        #12;
        check("reset_s_tick",   32'(bus.s_tick),   32'd0);
        check("reset_mid_tick", 32'(bus.mid_tick), 32'd0);
        check("reset_b_tick",   32'(bus.b_tick),   32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // x16 oversampling from a fresh enable: s_tick every 10, mid on 8th, b every 160.
        bus.div_int = 16'd9; bus.div_frac = 4'd0; bus.osr = 5'd15; bus.en = 1'b1;
        clear_logs();
        st = step_n + 1;
        repeat (330) step();
        check("t1_first_s_latency", qat(s_q, 0) - st + 1, 10);
        check("t1_s_period",        qat(s_q, 1) - qat(s_q, 0), 10);
        check("t1_mid_on_8th",      qat(m_q, 0), qat(s_q, 7));
        check("t1_first_b",         qat(b_q, 0) - st + 1, 160);
        check("t1_b_period",        qat(b_q, 1) - qat(b_q, 0), 160);

        // Fractional divisor 9 + 8/16 after a restart.
        do_restart(9, 8, 15, r_step);
        run_until_s(32, 400);
        check("t2_restart_latency", qat(s_q, 0) - r_step + 1, 11);
        check("t2_interval_1",      qat(s_q, 1) - qat(s_q, 0), 10);
`ifdef BAUD_FRAC_EN
        check("t2_interval_2",      qat(s_q, 2) - qat(s_q, 1), 11);
        check("t2_span_32",         qat(s_q, 31) - qat(s_q, 0) + 10, 335);
`else
        check("t2_interval_2",      qat(s_q, 2) - qat(s_q, 1), 10);
        check("t2_span_32",         qat(s_q, 31) - qat(s_q, 0) + 10, 320);
`endif

        // Divisor change mid-bit takes effect only after the next b_tick.
        do_restart(9, 0, 15, r_step);
        run_until_s(5, 100);
        bus.div_int = 16'd4;
        run_until_s(18, 300);
        check("t3_mid_bit_period",  qat(s_q, 6) - qat(s_q, 5), 10);
        check("t3_last_old_period", qat(s_q, 15) - qat(s_q, 14), 10);
        check("t3_b_at_16th",       qat(b_q, 0), qat(s_q, 15));
        check("t3_new_period",      qat(s_q, 16) - qat(s_q, 15), 5);
        check("t3_new_period_2",    qat(s_q, 17) - qat(s_q, 16), 5);

        // Restart six clocks into a period.
        do_restart(9, 0, 15, r_step);
        run_until_s(2, 50);
        repeat (6) step();
        do_restart(9, 0, 15, r_step);
        run_until_s(16, 250);
        check("t4_restart_latency", qat(s_q, 0) - r_step + 1, 11);
        check("t4_b_at_16th",       qat(b_q, 0), qat(s_q, 15));
        check("t4_b_count",         b_q.size(), 1);

        // Enable held low for 7 clocks three clocks into a period.
        clear_logs();
        run_until_s(1, 30);
        repeat (3) step();
        bus.en = 1'b0;
        repeat (7) step();
        bus.en = 1'b1;
        run_until_s(2, 40);
        check("t5_pause_stretch",   qat(s_q, 1) - qat(s_q, 0), 17);

        // Async reset while s_tick is high: outputs must drop at once.
        clear_logs();
        run_until_s(1, 30);
        reset_n = 1'b0;
        #1;
        check("t5_rst_s_tick",   32'(bus.s_tick),   32'd0);
        check("t5_rst_mid_tick", 32'(bus.mid_tick), 32'd0);
        check("t5_rst_b_tick",   32'(bus.b_tick),   32'd0);
        model_reset();
        #2;
        reset_n = 1'b1;
        clear_logs();
        st = step_n + 1;
        run_until_s(1, 30);
        check("t5_post_reset_latency", qat(s_q, 0) - st + 1, 10);

        // Divide by one, one sample per bit: all strobes every clock.
        do_restart(0, 0, 0, r_step);
        repeat (20) step();
        cnt_s = s_q.size(); cnt_m = m_q.size(); cnt_b = b_q.size();
        check("t6_s_every_clk",   cnt_s, 20);
        check("t6_mid_every_clk", cnt_m, 20);
        check("t6_b_every_clk",   cnt_b, 20);

        // Randomised runs: config inputs wander mid-bit, en drops, occasional restart.
        for (int seg = 0; seg < 6; seg++) begin
            do_restart(int'($urandom_range(0, 11)), int'($urandom_range(0, 15)),
                       int'($urandom_range(0, 7)), r_step);
            for (int c = 0; c < 200; c++) begin
                if ($urandom_range(0, 3) == 0) begin
                    bus.div_int  = DIV_W'($urandom_range(0, 11));
                    bus.div_frac = FRAC_W'($urandom_range(0, 15));
                    bus.osr      = OSR_W'($urandom_range(0, 7));
                end
                bus.en      = ($urandom_range(0, 9) != 0);
                bus.restart = ($urandom_range(0, 79) == 0);
                step();
            end
            bus.restart = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
